// File: rtl/kronos_branch_unit.sv
// Execute-stage branch resolution: comparator plus a registered valid/ready result stage.
// Optional build macro: KRONOS_BRANCH_MISALIGN_TRAP_EN adds branch_misaligned and gates the redirect.

module kronos_branch (
    input  logic [2:0]  op,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    output logic        branch
);

    always_comb begin
        // NOTE: assign a default before the case so no path leaves branch unassigned (avoids a latch).
        branch = 1'b0;
        unique case (op)
            3'b000:  branch = (rs1 == rs2);
            3'b001:  branch = (rs1 != rs2);
            3'b100:  branch = ($signed(rs1) <  $signed(rs2));
            3'b101:  branch = ($signed(rs1) >= $signed(rs2));
            3'b110:  branch = (rs1 <  rs2);
            3'b111:  branch = (rs1 >= rs2);
            default: branch = 1'b0;
        endcase
    end

endmodule

module kronos_branch_unit #(
    parameter logic [31:0] BOOT_ADDR = 32'h0
) (
    input  logic        clk,
    input  logic        rstz,
    input  logic        flush,
    input  logic        decode_vld,
    output logic        decode_rdy,
    input  logic [31:0] decode_pc,
    input  logic [31:0] decode_imm,
    input  logic [2:0]  decode_op,
    input  logic [31:0] decode_rs1,
    input  logic [31:0] decode_rs2,
    input  logic        decode_jump,
    input  logic        decode_jalr,
    output logic        branch_vld,
    input  logic        branch_rdy,
    output logic        branch_taken,
    output logic [31:0] branch_target,
    output logic [31:0] branch_link,
`ifdef KRONOS_BRANCH_MISALIGN_TRAP_EN
    output logic        branch_misaligned,
`endif
    output logic        branch_redirect
);

    typedef enum logic {EMPTY, FULL} state_e;

    state_e      state_q, state_d;
    logic        taken_q, taken_d;
    logic [31:0] target_q, target_d;
    logic [31:0] link_q, link_d;
    logic        redirect_q, redirect_d;
    logic        misaligned_q, misaligned_d;

    logic        cmp_branch;
    logic        load;
    logic        taken_new;
    logic        misaligned_new;
    logic [31:0] target_new;
    logic [31:0] jalr_sum;

    kronos_branch u_cmp (
        .op     (decode_op),
        .rs1    (decode_rs1),
        .rs2    (decode_rs2),
        .branch (cmp_branch)
    );

    assign branch_vld = (state_q == FULL);
    assign decode_rdy = ~branch_vld | branch_rdy;
    // A handshake during flush is discarded, so it never loads the result registers.
    assign load       = decode_vld & decode_rdy & ~flush;

    assign jalr_sum   = decode_rs1 + decode_imm;
    assign target_new = decode_jalr ? {jalr_sum[31:1], 1'b0} : (decode_pc + decode_imm);
    assign taken_new  = decode_jump | cmp_branch;

`ifdef KRONOS_BRANCH_MISALIGN_TRAP_EN
    assign misaligned_new = taken_new & target_new[1];
`else
    assign misaligned_new = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        taken_d      = taken_q;
        target_d     = target_q;
        link_d       = link_q;
        misaligned_d = misaligned_q;
        redirect_d   = 1'b0;

        unique case (state_q)
            EMPTY: if (load) state_d = FULL;
            FULL:  if (branch_rdy && !load) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase

        if (flush) state_d = EMPTY;

        if (load) begin
            taken_d      = taken_new;
            target_d     = target_new;
            link_d       = decode_pc + 32'd4;
            misaligned_d = misaligned_new;
            // Redirect pulses only on the load cycle, so a stalled result never re-fires it.
            redirect_d   = taken_new & ~misaligned_new;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rstz) begin
            state_q      <= EMPTY;
            taken_q      <= 1'b0;
            target_q     <= BOOT_ADDR;
            link_q       <= 32'h0;
            redirect_q   <= 1'b0;
            misaligned_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            taken_q      <= taken_d;
            target_q     <= target_d;
            link_q       <= link_d;
            redirect_q   <= redirect_d;
            misaligned_q <= misaligned_d;
        end
    end

    assign branch_taken    = taken_q;
    assign branch_target   = target_q;
    assign branch_link     = link_q;
    assign branch_redirect = redirect_q;
`ifdef KRONOS_BRANCH_MISALIGN_TRAP_EN
    assign branch_misaligned = misaligned_q;
`else
    logic unused_misaligned;
    assign unused_misaligned = misaligned_q;
`endif

endmodule

// File: tb/tb_kronos_branch_unit.sv
// Directed self-checking bench for kronos_branch_unit; inputs driven and outputs sampled on the falling edge.

module tb_kronos_branch_unit;

    localparam logic [31:0] BOOT = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rstz, flush, decode_vld, decode_rdy, decode_jump, decode_jalr;
    logic [31:0] decode_pc, decode_imm, decode_rs1, decode_rs2;
    logic [2:0]  decode_op;
    logic        branch_vld, branch_rdy, branch_taken, branch_redirect;
    logic [31:0] branch_target, branch_link;
`ifdef KRONOS_BRANCH_MISALIGN_TRAP_EN
    logic        branch_misaligned;
`endif

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    kronos_branch_unit #(.BOOT_ADDR(BOOT)) dut (
        .clk            (clk),
        .rstz           (rstz),
        .flush          (flush),
        .decode_vld     (decode_vld),
        .decode_rdy     (decode_rdy),
        .decode_pc      (decode_pc),
        .decode_imm     (decode_imm),
        .decode_op      (decode_op),
        .decode_rs1     (decode_rs1),
        .decode_rs2     (decode_rs2),
        .decode_jump    (decode_jump),
        .decode_jalr    (decode_jalr),
        .branch_vld     (branch_vld),
        .branch_rdy     (branch_rdy),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
        .branch_link    (branch_link),
`ifdef KRONOS_BRANCH_MISALIGN_TRAP_EN
        .branch_misaligned (branch_misaligned),
`endif
        .branch_redirect (branch_redirect)
    );

    task automatic drive(input logic [2:0] op, input logic [31:0] pc, input logic [31:0] imm,
                         input logic [31:0] rs1, input logic [31:0] rs2,
                         input logic jump, input logic jalr);
        decode_vld  = 1'b1;
        decode_op   = op;
        decode_pc   = pc;
        decode_imm  = imm;
        decode_rs1  = rs1;
        decode_rs2  = rs2;
        decode_jump = jump;
        decode_jalr = jalr;
    endtask

    task automatic test_reset();
        rstz = 1'b0; flush = 1'b0; decode_vld = 1'b0; branch_rdy = 1'b1;
        drive(3'b000, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        decode_vld = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (branch_vld !== 1'b0) $display("FAIL reset_vld got %0b want 0", branch_vld); else passed++;
        total++; if (branch_taken !== 1'b0) $display("FAIL reset_taken got %0b want 0", branch_taken); else passed++;
        total++; if (branch_redirect !== 1'b0) $display("FAIL reset_redirect got %0b want 0", branch_redirect); else passed++;
        total++; if (branch_target !== BOOT) $display("FAIL reset_target got %h want %h", branch_target, BOOT); else passed++;
        total++; if (branch_link !== 32'h0) $display("FAIL reset_link got %h want 0", branch_link); else passed++;
        total++; if (decode_rdy !== 1'b1) $display("FAIL reset_decode_rdy got %0b want 1", decode_rdy); else passed++;
`ifdef KRONOS_BRANCH_MISALIGN_TRAP_EN
        total++; if (branch_misaligned !== 1'b0) $display("FAIL reset_misaligned got %0b want 0", branch_misaligned); else passed++;
`endif
        rstz = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_beq();
        drive(3'b000, 32'h100, 32'h20, 32'h1234, 32'h1234, 1'b0, 1'b0);
        @(negedge clk);
        decode_vld = 1'b0;
        total++; if (branch_vld !== 1'b1) $display("FAIL beq_vld got %0b want 1", branch_vld); else passed++;
        total++; if (branch_taken !== 1'b1) $display("FAIL beq_taken got %0b want 1", branch_taken); else passed++;
        total++; if (branch_target !== 32'h120) $display("FAIL beq_target got %h want 00000120", branch_target); else passed++;
        total++; if (branch_link !== 32'h104) $display("FAIL beq_link got %h want 00000104", branch_link); else passed++;
        total++; if (branch_redirect !== 1'b1) $display("FAIL beq_redirect got %0b want 1", branch_redirect); else passed++;
        @(negedge clk);
        total++; if (branch_vld !== 1'b0) $display("FAIL beq_drain_vld got %0b want 0", branch_vld); else passed++;
        total++; if (branch_redirect !== 1'b0) $display("FAIL beq_pulse_len got %0b want 0", branch_redirect); else passed++;
    endtask

    task automatic test_blt_bltu();
        drive(3'b100, 32'h200, 32'h40, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0);
        @(negedge clk);
        total++; if (branch_taken !== 1'b1) $display("FAIL blt_taken got %0b want 1", branch_taken); else passed++;
        drive(3'b110, 32'h200, 32'h40, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0);
        @(negedge clk);
        decode_vld = 1'b0;
        total++; if (branch_vld !== 1'b1) $display("FAIL bltu_vld got %0b want 1", branch_vld); else passed++;
        total++; if (branch_taken !== 1'b0) $display("FAIL bltu_taken got %0b want 0", branch_taken); else passed++;
        total++; if (branch_redirect !== 1'b0) $display("FAIL bltu_redirect got %0b want 0", branch_redirect); else passed++;
        total++; if (branch_link !== 32'h204) $display("FAIL bltu_link got %h want 00000204", branch_link); else passed++;
        @(negedge clk);
    endtask

    task automatic test_jalr();
        drive(3'b000, 32'h300, 32'h4, 32'h2003, 32'h0, 1'b1, 1'b1);
        @(negedge clk);
        decode_vld = 1'b0;
        total++; if (branch_taken !== 1'b1) $display("FAIL jalr_taken got %0b want 1", branch_taken); else passed++;
        total++; if (branch_target !== 32'h2006) $display("FAIL jalr_target got %h want 00002006", branch_target); else passed++;
        total++; if (branch_link !== 32'h304) $display("FAIL jalr_link got %h want 00000304", branch_link); else passed++;
`ifdef KRONOS_BRANCH_MISALIGN_TRAP_EN
        total++; if (branch_misaligned !== 1'b1) $display("FAIL jalr_misaligned got %0b want 1", branch_misaligned); else passed++;
        total++; if (branch_redirect !== 1'b0) $display("FAIL jalr_redirect got %0b want 0", branch_redirect); else passed++;
`else
        total++; if (branch_redirect !== 1'b1) $display("FAIL jalr_redirect got %0b want 1", branch_redirect); else passed++;
`endif
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        branch_rdy = 1'b0;
        drive(3'b000, 32'h400, 32'h10, 32'h0, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        // Next instruction waits on decode_rdy while the result stalls.
        drive(3'b001, 32'h500, 32'h40, 32'h1, 32'h2, 1'b0, 1'b0);
        total++; if (branch_redirect !== 1'b1) $display("FAIL stall_first_redirect got %0b want 1", branch_redirect); else passed++;
        total++; if (decode_rdy !== 1'b0) $display("FAIL stall_decode_rdy got %0b want 0", decode_rdy); else passed++;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            total++; if (branch_vld !== 1'b1) $display("FAIL stall_vld[%0d] got %0b want 1", i, branch_vld); else passed++;
            total++; if (branch_target !== 32'h410) $display("FAIL stall_target[%0d] got %h want 00000410", i, branch_target); else passed++;
            total++; if (branch_link !== 32'h404) $display("FAIL stall_link[%0d] got %h want 00000404", i, branch_link); else passed++;
            total++; if (branch_redirect !== 1'b0) $display("FAIL stall_redirect[%0d] got %0b want 0", i, branch_redirect); else passed++;
            total++; if (decode_rdy !== 1'b0) $display("FAIL stall_rdy[%0d] got %0b want 0", i, decode_rdy); else passed++;
        end
        branch_rdy = 1'b1;
        @(negedge clk);
        decode_vld = 1'b0;
        total++; if (branch_vld !== 1'b1) $display("FAIL b2b_vld got %0b want 1", branch_vld); else passed++;
        total++; if (branch_target !== 32'h540) $display("FAIL b2b_target got %h want 00000540", branch_target); else passed++;
        total++; if (branch_link !== 32'h504) $display("FAIL b2b_link got %h want 00000504", branch_link); else passed++;
        total++; if (branch_redirect !== 1'b1) $display("FAIL b2b_redirect got %0b want 1", branch_redirect); else passed++;
        @(negedge clk);
    endtask

    task automatic test_flush();
        branch_rdy = 1'b0;
        drive(3'b000, 32'h600, 32'h8, 32'h0, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        branch_rdy = 1'b1;
        flush = 1'b1;
        drive(3'b000, 32'h700, 32'h8, 32'h0, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        flush = 1'b0;
        decode_vld = 1'b0;
        total++; if (branch_vld !== 1'b0) $display("FAIL flush_vld got %0b want 0", branch_vld); else passed++;
        total++; if (branch_redirect !== 1'b0) $display("FAIL flush_redirect got %0b want 0", branch_redirect); else passed++;
        @(negedge clk);
        total++; if (branch_vld !== 1'b0) $display("FAIL flush_discard_vld got %0b want 0", branch_vld); else passed++;
    endtask

    task automatic test_reset_mid();
        branch_rdy = 1'b0;
        drive(3'b000, 32'h800, 32'h10, 32'h0, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        decode_vld = 1'b0;
        rstz = 1'b0;
        @(negedge clk);
        total++; if (branch_vld !== 1'b0) $display("FAIL rstmid_vld got %0b want 0", branch_vld); else passed++;
        total++; if (branch_target !== BOOT) $display("FAIL rstmid_target got %h want %h", branch_target, BOOT); else passed++;
        total++; if (branch_redirect !== 1'b0) $display("FAIL rstmid_redirect got %0b want 0", branch_redirect); else passed++;
        total++; if (decode_rdy !== 1'b1) $display("FAIL rstmid_decode_rdy got %0b want 1", decode_rdy); else passed++;
        rstz = 1'b1;
        branch_rdy = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_wrap();
        drive(3'b000, 32'hFFFF_FFFC, 32'h8, 32'h0, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        decode_vld = 1'b0;
        total++; if (branch_target !== 32'h4) $display("FAIL wrap_target got %h want 00000004", branch_target); else passed++;
        total++; if (branch_link !== 32'h0) $display("FAIL wrap_link got %h want 00000000", branch_link); else passed++;
        total++; if (branch_taken !== 1'b1) $display("FAIL wrap_taken got %0b want 1", branch_taken); else passed++;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_beq();
        test_blt_bltu();
        test_jalr();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        test_wrap();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
